// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data-type codes, lane geometry and the
// packet decoder state encoding. The RAW depacker imports this package too.
package mipi_csi_pkg;

  // Lane geometry: two lanes, one byte per lane per byte-clock.
  localparam int LANES  = 2;
  localparam int GEAR   = 8;
  localparam int BEAT_W = LANES * GEAR;

  // CSI-2 data identifiers recognised by the decoder.
  localparam logic [7:0] DT_FS    = 8'h00;
  localparam logic [7:0] DT_FE    = 8'h01;
  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;
  localparam logic [7:0] DT_RAW14 = 8'h2D;

  // Low DI bits forwarded to the depacker as the packet type.
  localparam logic [2:0] DT_TYPE_MASK = 3'h7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR1,
    ST_PAYLOAD,
    ST_DRAIN
  } dec_state_e;

  // True for the RAW long-packet types the depacker understands.
  function automatic logic is_raw_dt(input logic [7:0] di);
    return (di == DT_RAW10) || (di == DT_RAW12) || (di == DT_RAW14);
  endfunction

endpackage

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane_if.sv
// Beat stream between the 2-lane byte aligner, the packet decoder and the
// RAW depacker. master = aligner side, slave = packet decoder.
interface mipi_csi_rx_packet_decoder_8b2lane_if;
  import mipi_csi_pkg::*;

  logic              data_valid_i;
  logic [BEAT_W-1:0] data_i;
  logic              output_valid_o;
  logic [BEAT_W-1:0] data_o;
  logic [2:0]        packet_type_o;
  logic              frame_start_o;
  logic              frame_end_o;

  modport master (
    output data_valid_i, data_i,
    input  output_valid_o, data_o, packet_type_o, frame_start_o, frame_end_o
  );

  modport slave (
    input  data_valid_i, data_i,
    output output_valid_o, data_o, packet_type_o, frame_start_o, frame_end_o
  );

endinterface

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// CSI-2 packet decoder for a 2-lane, 8-bit gear byte stream. Strips the
// 4-byte header, forwards word-count bytes of RAW payload with one cycle of
// latency, and pulses frame-start / frame-end on the matching short packets.
module mipi_csi_rx_packet_decoder_8b2lane
  import mipi_csi_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  mipi_csi_rx_packet_decoder_8b2lane_if.slave bus
);

  dec_state_e        state_q, state_d;
  logic [7:0]        di_q, di_d;
  logic [7:0]        wc_lo_q, wc_lo_d;
  logic [15:0]       remaining_q, remaining_d;
  logic              output_valid_q, output_valid_d;
  logic [BEAT_W-1:0] data_q, data_d;
  logic [2:0]        packet_type_q, packet_type_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;

  logic [15:0]       wc_full;

  // Full word count, valid while the second header beat is on the bus.
  assign wc_full = {bus.data_i[GEAR-1:0], wc_lo_q};

  // Header decode, payload counting and output staging.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d        = state_q;
    di_d           = di_q;
    wc_lo_d        = wc_lo_q;
    remaining_d    = remaining_q;
    output_valid_d = 1'b0;
    data_d         = data_q;
    packet_type_d  = packet_type_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid_i) begin
          di_d    = bus.data_i[GEAR-1:0];
          wc_lo_d = bus.data_i[BEAT_W-1:GEAR];
          state_d = ST_HDR1;
        end
      end

      ST_HDR1: begin
        if (!bus.data_valid_i) begin
          // Header cut short: drop it without any side effect.
          state_d = ST_IDLE;
        end else if (is_raw_dt(di_q) && (wc_full != 16'd0)) begin
          remaining_d   = wc_full;
          packet_type_d = di_q[2:0] & DT_TYPE_MASK;
          state_d       = ST_PAYLOAD;
        end else begin
          frame_start_d = (di_q == DT_FS);
          frame_end_d   = (di_q == DT_FE);
          state_d       = ST_DRAIN;
        end
      end

      ST_PAYLOAD: begin
        if (!bus.data_valid_i) begin
          // Truncated packet: forget what was left to receive.
          remaining_d = 16'd0;
          state_d     = ST_IDLE;
        end else begin
          output_valid_d = 1'b1;
          data_d         = bus.data_i;
          if (remaining_q <= 16'd2) begin
            remaining_d = 16'd0;
            state_d     = ST_DRAIN;
          end else begin
            remaining_d = remaining_q - 16'd2;
          end
        end
      end

      ST_DRAIN: begin
        // CRC, trailer and filler beats are swallowed here.
        if (!bus.data_valid_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by reset_i.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (reset_i) begin
      state_q        <= ST_IDLE;
      di_q           <= 8'h00;
      wc_lo_q        <= 8'h00;
      remaining_q    <= 16'd0;
      output_valid_q <= 1'b0;
      data_q         <= '0;
      packet_type_q  <= 3'd0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      di_q           <= di_d;
      wc_lo_q        <= wc_lo_d;
      remaining_q    <= remaining_d;
      output_valid_q <= output_valid_d;
      data_q         <= data_d;
      packet_type_q  <= packet_type_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
    end
  end

  assign bus.output_valid_o = output_valid_q;
  assign bus.data_o         = data_q;
  assign bus.packet_type_o  = packet_type_q;
  assign bus.frame_start_o  = frame_start_q;
  assign bus.frame_end_o    = frame_end_q;

endmodule

// File: doc/mipi_csi_rx_packet_decoder_8b2lane.md
# mipi_csi_rx_packet_decoder_8b2lane

Parses the CSI-2 packet stream from the 2-lane byte aligner: decodes the 4-byte packet header, strips it, and forwards exactly word-count bytes of long-packet payload. It also signals frame-start and frame-end short packets. It sits directly upstream of the 2-lane RAW depacker and drives its `data_valid_i`, `data_i` and `packet_type_i` inputs.

## Interface
- No parameters. Lane count (2) and gear (8 bits per lane per clock) are fixed localparams.
- `clk_i` in 1: byte clock, shared with the aligner and the depacker.
- `reset_i` in 1: asynchronous, active-high.
- `data_valid_i` in 1: from the aligner; high for every beat of one packet, starting with the first header beat. Low between packets.
- `data_i` in 16: `[7:0]` is the lane 0 byte, `[15:8]` is the lane 1 byte.
- `output_valid_o` out 1: high for each payload beat.
- `data_o` out 16: payload beat, with the same lane ordering as `data_i`.
- `packet_type_o` out 3: `DI[2:0]` of the most recent accepted RAW long packet.
- `frame_start_o` out 1: one-cycle pulse on a DI 0x00 short packet.
- `frame_end_o` out 1: one-cycle pulse on a DI 0x01 short packet.

## Operation
- Header layout across the two beats:
  - Beat 0: lane 0 = DI, lane 1 = WC[7:0].
  - Beat 1: lane 0 = WC[15:8], lane 1 = ECC.
  - ECC is not checked.
- State machine: IDLE, HDR1, PAYLOAD, DRAIN.
- IDLE:
  - On `data_valid_i`=1, capture DI and WC low byte, go to HDR1.
- HDR1 (requires `data_valid_i`=1), capture WC high byte, then:
  - DI is 0x2B, 0x2C or 0x2D and WC≠0: load `remaining`=WC (16 bits), update `packet_type_o`, go to PAYLOAD.
  - DI=0x00: pulse `frame_start_o`, go to DRAIN.
  - DI=0x01: pulse `frame_end_o`, go to DRAIN.
  - Any other DI, or WC=0: go to DRAIN.
- PAYLOAD:
  - Each valid beat is registered to `data_o` with `output_valid_o`=1, and `remaining` decrements by 2.
  - When `remaining`≤2 the beat is the last one: go to DRAIN.
  - Odd WC: the final beat is still emitted; `data_o[15:8]` is don't-care on that beat.
- DRAIN:
  - Ignore beats (CRC, trailer, filler) until `data_valid_i`=0, then go to IDLE.
- `data_valid_i`=0 in any state: go to IDLE next cycle.
  - In PAYLOAD this is a truncated packet. `output_valid_o` drops and `remaining` is discarded.
- `data_valid_i`=0 in HDR1: abort to IDLE. No pulse and no `packet_type_o` update.
- `packet_type_o` holds its value across packets and short packets. It changes only on an accepted RAW long-packet header.
  - This is required because the depacker samples `packet_type_i` while its `data_valid_i` is low.
- `data_o` holds its last value when `output_valid_o`=0.

## Timing
- Reset values: state IDLE, `output_valid_o`=0, `data_o`=0, `packet_type_o`=0, `frame_start_o`=0, `frame_end_o`=0, `remaining`=0.
- Header beat 0 arrives at cycle T and beat 1 at T+1. `packet_type_o` updates at the T+2 edge.
- The first payload beat arrives at T+2 and appears on `data_o` with `output_valid_o`=1 after the T+3 edge.
  - Input-to-output latency is 1 cycle for every payload beat.
  - `packet_type_o` is therefore stable at least 1 cycle before `output_valid_o` rises.
- `output_valid_o` is high for exactly ceil(WC/2) consecutive cycles when no truncation occurs.
- `frame_start_o` and `frame_end_o` assert for exactly one cycle, after the T+2 edge.
- Back-to-back packets: a new header is accepted on the first `data_valid_i`=1 beat after at least one low cycle.
- Asynchronous reset mid-packet:
  - All outputs clear immediately.
  - After release, the block waits in IDLE. If `data_valid_i` is still high, the next beat is treated as header beat 0; the aligner is responsible for dropping `data_valid_i` first.

## Structure
- Shared package `mipi_csi_pkg`:
  - Data-type constants: FS 0x00, FE 0x01, RAW10 0x2B, RAW12 0x2C, RAW14 0x2D.
  - The 3-bit type mask 0x07.
  - Lane and gear localparams.
  - The depacker imports the same package.
- No sub-module. The FSM, the 16-bit `remaining` counter and the output registers fit in one module.

## Test plan
- Reset, then a RAW10 header (DI 0x2B, WC 0x000A) followed by 5 payload beats 0x0201…0x0A09 and 1 CRC beat -> `packet_type_o`=3 one cycle before valid; `output_valid_o` high 5 cycles with `data_o` 0x0201…0x0A09 in order; CRC beat not forwarded.
- FS short packet (0x00), then FE short packet (0x01) -> `frame_start_o`, then `frame_end_o`, each a single one-cycle pulse; no `output_valid_o`; `packet_type_o` unchanged.
- RAW12 header with WC=7 -> 4 valid beats; the last beat's lane 0 byte is correct.
- RAW14 header with WC 0x0010, `data_valid_i` dropped after 3 payload beats -> 3 valid outputs, then IDLE; the next header decodes correctly.
- DI 0x12 (embedded data) with WC=4 -> no output, no pulses, `packet_type_o` retained.
- `reset_i` asserted mid-payload -> all outputs 0 in the same cycle; after release with `data_valid_i` low, a RAW10 packet decodes normally.
